// File: rtl/piece_mover.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | piece_mover: turns gameplay commands into tetromino moves, checks the  |
// | four candidate cells against the board and commits or rejects them.    |
// | Optional macro WALL_KICK_EN: blocked rotations retry at x-1, then x+1. |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module piece_mover #(
  parameter int COLS    = 10,
  parameter int ROWS    = 20,
  parameter int SPAWN_X = 3,
  parameter int XW      = 4,
  parameter int YW      = 5
) (
  input  logic          Clk,
  input  logic          Resetn,
  input  logic [3:0]    changeblock,
  input  logic          spawn,
  input  logic [2:0]    spawn_type,
  output logic          query_valid,
  output logic [XW-1:0] query_x,
  output logic [YW-1:0] query_y,
  input  logic          query_occ,
  output logic [XW-1:0] piece_x,
  output logic [YW-1:0] piece_y,
  output logic [1:0]    piece_rot,
  output logic [2:0]    piece_type,
  output logic          busy,
  output logic          moved,
  output logic          lock,
  output logic          game_over
);
  localparam logic [3:0] C_NOTPLAY = 4'b0000;
  localparam logic [3:0] C_DROP    = 4'b0010;
  localparam logic [3:0] C_LEFT    = 4'b0011;
  localparam logic [3:0] C_RIGHT   = 4'b0100;
  localparam logic [3:0] C_DOWN    = 4'b0101;
  localparam logic [3:0] C_ROT     = 4'b0110;

  localparam logic [XW:0] COLS_X   = COLS[XW:0];
  localparam logic [YW:0] ROWS_Y   = ROWS[YW:0];
  localparam logic [XW:0] SPAWN_XX = SPAWN_X[XW:0];
  localparam logic [XW:0] ONE_X    = {{XW{1'b0}}, 1'b1};
  localparam logic [YW:0] ONE_Y    = {{YW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, RESOLVE = 2'd2} state_t;
  state_t state, state_nxt;

  // Positions carry an extra sign bit so boxes may hang past the left wall.
  logic [XW:0] px, cx, cell_x;
  logic [YW:0] py, cy, cell_y;
  logic [1:0]  prot, crot, idx, kick, dx, dy;
  logic [2:0]  ptype, ctype, stype;
  logic [3:0]  cop, pend_code, code_sel;
  logic        cspawn, blocked, prev_chk, prev_oob, pend_v, cell_oob;
  logic        abort, start_spawn, start_pend, start_cur, commit, retry;
  logic        lock_hit, kick_ok, blocked_now;

  function automatic logic is_action(input logic [3:0] c);
    return (c >= C_DROP) && (c <= C_ROT);
  endfunction

  // Returns {dx, dy} of cell k; each nibble of the table is one {dx, dy} pair.
  function automatic logic [3:0] cell_offset(input logic [2:0] t, input logic [1:0] r,
                                             input logic [1:0] k);
    logic [15:0] cells;
    logic [1:0]  smax, ox, oy, tmp;
    case (t)
      3'd1:    begin cells = 16'h5140; smax = 2'd1; end
      3'd2:    begin cells = 16'h9514; smax = 2'd2; end
      3'd3:    begin cells = 16'h5184; smax = 2'd2; end
      3'd4:    begin cells = 16'h9540; smax = 2'd2; end
      3'd5:    begin cells = 16'h9510; smax = 2'd2; end
      3'd6:    begin cells = 16'h9518; smax = 2'd2; end
      default: begin cells = 16'hD951; smax = 2'd3; end
    endcase
    ox = cells[{k, 2'b10} +: 2];
    oy = cells[{k, 2'b00} +: 2];
    for (int i = 0; i < 3; i++) begin
      if (r > 2'(i)) begin
        tmp = smax - oy;
        oy  = ox;
        ox  = tmp;
      end
    end
    return {ox, oy};
  endfunction

  always_comb begin
    {dx, dy}    = cell_offset(ctype, crot, idx);
    cell_x      = cx + {{(XW-1){1'b0}}, dx};
    cell_y      = cy + {{(YW-1){1'b0}}, dy};
    cell_oob    = cell_x[XW] || (cell_x >= COLS_X) || cell_y[YW] || (cell_y >= ROWS_Y);
    query_valid = (state == CHECK) && !cell_oob;
    query_x     = cell_x[XW-1:0];
    query_y     = cell_y[YW-1:0];
  end

  assign piece_x    = px[XW-1:0];
  assign piece_y    = py[YW-1:0];
  assign piece_rot  = prot;
  assign piece_type = ptype;
  assign busy       = (state != IDLE);
  assign stype      = (spawn_type == 3'd7) ? 3'd0 : spawn_type;
  assign code_sel   = start_pend ? pend_code : changeblock;

  always_ff @(posedge Clk) begin
    if (!Resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    abort       = (changeblock == C_NOTPLAY);
    start_spawn = 1'b0;
    start_pend  = 1'b0;
    start_cur   = 1'b0;
    commit      = 1'b0;
    retry       = 1'b0;
    lock_hit    = 1'b0;
    blocked_now = blocked | (prev_chk & (prev_oob | query_occ));
`ifdef WALL_KICK_EN
    kick_ok     = (cop == C_ROT) && (kick != 2'd2);
`else
    kick_ok     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (spawn)                       start_spawn = 1'b1;
        else if (!abort && pend_v)       start_pend  = 1'b1;
        else if (is_action(changeblock)) start_cur   = 1'b1;
        if (start_spawn || start_pend || start_cur) state_nxt = CHECK;
      end
      CHECK: begin
        if (abort)              state_nxt = IDLE;
        else if (idx == 2'd3)   state_nxt = RESOLVE;
      end
      RESOLVE: begin
        state_nxt = IDLE;
        if (abort) begin
          state_nxt = IDLE;
        end else if (!blocked_now || cspawn) begin
          commit = 1'b1;
        end else if (kick_ok) begin
          retry     = 1'b1;
          state_nxt = CHECK;
        end else if ((cop == C_DROP) || (cop == C_DOWN)) begin
          lock_hit = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      px <= SPAWN_XX;  py <= '0;  prot <= '0;  ptype <= '0;
      cx <= '0;  cy <= '0;  crot <= '0;  ctype <= '0;
      cop <= C_NOTPLAY;  cspawn <= 1'b0;  idx <= '0;  kick <= '0;
      blocked <= 1'b0;  prev_chk <= 1'b0;  prev_oob <= 1'b0;
      pend_v <= 1'b0;  pend_code <= C_NOTPLAY;
      moved <= 1'b0;  lock <= 1'b0;  game_over <= 1'b0;
    end else begin
      prev_chk  <= (state == CHECK);
      prev_oob  <= cell_oob;
      moved     <= commit & ~blocked_now;
      game_over <= commit & blocked_now;
      lock      <= lock_hit;
      if (state != IDLE) begin
        idx     <= idx + 2'd1;
        blocked <= blocked_now;
      end
      if (start_spawn) begin
        cx <= SPAWN_XX;  cy <= '0;  crot <= '0;  ctype <= stype;
        ptype <= stype;  cspawn <= 1'b1;  cop <= C_NOTPLAY;
      end else if (start_pend || start_cur) begin
        cx <= px;  cy <= py;  crot <= prot;  ctype <= ptype;
        cspawn <= 1'b0;  cop <= code_sel;
        case (code_sel)
          C_DROP, C_DOWN: cy   <= py + ONE_Y;
          C_LEFT:         cx   <= px - ONE_X;
          C_RIGHT:        cx   <= px + ONE_X;
          C_ROT:          crot <= prot + 2'd1;
          default:        ;
        endcase
      end
      if (start_spawn || start_pend || start_cur) begin
        idx <= '0;  blocked <= 1'b0;  kick <= '0;
      end
      if (retry) begin
        cx      <= (kick == 2'd0) ? (px - ONE_X) : (px + ONE_X);
        idx     <= '0;
        blocked <= 1'b0;
        kick    <= kick + 2'd1;
      end
      if (commit) begin
        px <= cx;  py <= cy;  prot <= crot;  ptype <= ctype;
      end
      // Pending is one deep; a queued Drop survives later non-Drop codes.
      if (abort) begin
        pend_v <= 1'b0;
      end else if (is_action(changeblock) && (start_pend || state != IDLE || start_spawn)) begin
        if (start_pend || !(pend_v && pend_code == C_DROP && changeblock != C_DROP)) begin
          pend_v    <= 1'b1;
          pend_code <= changeblock;
        end
      end else if (start_pend) begin
        pend_v <= 1'b0;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_piece_mover.sv
`default_nettype none
// tb_piece_mover: directed checks of piece_mover timing, commit rules,
// pending queue, flush, reset and spawn handling.
module tb_piece_mover;
  localparam int COLS = 10, ROWS = 20, XW = 4, YW = 5;
  localparam logic [3:0] C_NP = 4'd0, C_WAIT = 4'd1, C_DROP = 4'd2, C_LEFT = 4'd3;
  localparam logic [3:0] C_RIGHT = 4'd4, C_DOWN = 4'd5, C_ROT = 4'd6;

  logic          Clk = 1'b0, Resetn = 1'b0, spawn = 1'b0, query_occ = 1'b0;
  logic [3:0]    changeblock = C_WAIT;
  logic [2:0]    spawn_type = 3'd0;
  logic          query_valid, busy, moved, lock, game_over;
  logic [XW-1:0] query_x, piece_x;
  logic [YW-1:0] query_y, piece_y;
  logic [1:0]    piece_rot;
  logic [2:0]    piece_type;
  logic          board [ROWS][COLS];
  int errors = 0, checks = 0, n_moved = 0, n_lock = 0, n_go = 0;
  int b_moved, b_lock, b_go;

  piece_mover dut (
    .Clk(Clk), .Resetn(Resetn), .changeblock(changeblock), .spawn(spawn),
    .spawn_type(spawn_type), .query_valid(query_valid), .query_x(query_x),
    .query_y(query_y), .query_occ(query_occ), .piece_x(piece_x), .piece_y(piece_y),
    .piece_rot(piece_rot), .piece_type(piece_type), .busy(busy), .moved(moved),
    .lock(lock), .game_over(game_over)
  );

  always #5 Clk = ~Clk;

  // Board store model with one cycle of read latency.
  always @(posedge Clk) query_occ <= query_valid ? board[query_y][query_x] : 1'b0;

  always @(posedge Clk) begin
    if (moved === 1'b1)     n_moved++;
    if (lock === 1'b1)      n_lock++;
    if (game_over === 1'b1) n_go++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic do_cmd(input logic [3:0] code);
    changeblock = code; tick(1); changeblock = C_WAIT; tick(5);
  endtask

  task automatic do_spawn(input logic [2:0] t);
    spawn = 1'b1; spawn_type = t; tick(1); spawn = 1'b0; tick(5);
  endtask

  task automatic test_reset;
    tick(3);
    checks++; if ({piece_x, piece_y, piece_rot, piece_type} !== {4'd3, 5'd0, 2'd0, 3'd0}) begin
      errors++; $display("FAIL reset_piece: got %h expected %h", {piece_x, piece_y, piece_rot, piece_type}, {4'd3, 5'd0, 2'd0, 3'd0}); end
    checks++; if ({busy, moved, lock, game_over, query_valid} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 00000", {busy, moved, lock, game_over, query_valid}); end
    Resetn = 1'b1; tick(1);
  endtask

  task automatic test_spawn;
    b_lock = n_lock; b_go = n_go;
    spawn = 1'b1; spawn_type = 3'd2; tick(1); spawn = 1'b0;
    checks++; if ({busy, query_valid, query_x, query_y, piece_type} !== {1'b1, 1'b1, 4'd4, 5'd0, 3'd2}) begin
      errors++; $display("FAIL spawn_query0: got %h expected %h", {busy, query_valid, query_x, query_y, piece_type}, {1'b1, 1'b1, 4'd4, 5'd0, 3'd2}); end
    tick(4);
    checks++; if (moved !== 1'b0) begin errors++; $display("FAIL spawn_early: moved got %b expected 0 in cycle 5", moved); end
    tick(1);
    checks++; if (moved !== 1'b1) begin errors++; $display("FAIL spawn_moved: got %b expected 1", moved); end
    checks++; if ({piece_x, piece_y, piece_rot, piece_type} !== {4'd3, 5'd0, 2'd0, 3'd2}) begin
      errors++; $display("FAIL spawn_piece: got %h expected %h", {piece_x, piece_y, piece_rot, piece_type}, {4'd3, 5'd0, 2'd0, 3'd2}); end
    tick(1);
    checks++; if ((n_lock - b_lock) + (n_go - b_go) !== 0) begin
      errors++; $display("FAIL spawn_no_lock_go: got %0d expected 0", (n_lock - b_lock) + (n_go - b_go)); end
  endtask

  task automatic test_left_oob;
    repeat (3) do_cmd(C_LEFT);
    checks++; if (piece_x !== 4'd0) begin errors++; $display("FAIL left_to_wall: got %0d expected 0", piece_x); end
    changeblock = C_LEFT; tick(1); changeblock = C_WAIT;
    checks++; if (query_valid !== 1'b1) begin errors++; $display("FAIL left_slot0_valid: got %b expected 1", query_valid); end
    tick(1);
    checks++; if (query_valid !== 1'b0) begin errors++; $display("FAIL left_slot1_oob: got %b expected 0", query_valid); end
    tick(4);
    checks++; if ({moved, lock, piece_x} !== {1'b0, 1'b0, 4'd0}) begin
      errors++; $display("FAIL left_blocked: got %h expected %h", {moved, lock, piece_x}, {1'b0, 1'b0, 4'd0}); end
  endtask

  task automatic test_drop_lock;
    tick(1); do_spawn(3'd1);
    repeat (18) do_cmd(C_DOWN);
    checks++; if (piece_y !== 5'd18) begin errors++; $display("FAIL down_to_18: got %0d expected 18", piece_y); end
    changeblock = C_DROP; tick(1); changeblock = C_WAIT; tick(4);
    checks++; if (lock !== 1'b0) begin errors++; $display("FAIL lock_early: got %b expected 0", lock); end
    tick(1);
    checks++; if ({lock, moved, piece_y} !== {1'b1, 1'b0, 5'd18}) begin
      errors++; $display("FAIL drop_lock: got %h expected %h", {lock, moved, piece_y}, {1'b1, 1'b0, 5'd18}); end
  endtask

  task automatic test_back_to_back;
    tick(1); do_spawn(3'd2); tick(1);
    b_moved = n_moved;
    changeblock = C_RIGHT; tick(3); changeblock = C_WAIT; tick(3);
    checks++; if ({moved, piece_x} !== {1'b1, 4'd4}) begin
      errors++; $display("FAIL b2b_first: got %h expected %h", {moved, piece_x}, {1'b1, 4'd4}); end
    tick(1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_pending_busy: got %b expected 1", busy); end
    tick(5);
    checks++; if ({moved, piece_x} !== {1'b1, 4'd5}) begin
      errors++; $display("FAIL b2b_second: got %h expected %h", {moved, piece_x}, {1'b1, 4'd5}); end
    tick(1);
    checks++; if (n_moved - b_moved !== 2) begin errors++; $display("FAIL b2b_pulses: got %0d expected 2", n_moved - b_moved); end
  endtask

  task automatic test_pending_drop;
    b_moved = n_moved;
    changeblock = C_RIGHT; tick(1); changeblock = C_DROP; tick(1);
    changeblock = C_LEFT; tick(1); changeblock = C_WAIT; tick(3);
    checks++; if ({piece_x, piece_y} !== {4'd6, 5'd0}) begin
      errors++; $display("FAIL pend_first: got %h expected %h", {piece_x, piece_y}, {4'd6, 5'd0}); end
    tick(6);
    checks++; if ({moved, piece_x, piece_y} !== {1'b1, 4'd6, 5'd1}) begin
      errors++; $display("FAIL pend_drop_kept: got %h expected %h", {moved, piece_x, piece_y}, {1'b1, 4'd6, 5'd1}); end
    tick(1);
    checks++; if ({busy, n_moved - b_moved} !== {1'b0, 32'd2}) begin
      errors++; $display("FAIL pend_left_dropped: got busy=%b pulses=%0d expected busy=0 pulses=2", busy, n_moved - b_moved); end
  endtask

  task automatic test_notplay;
    tick(1); b_moved = n_moved;
    changeblock = C_RIGHT; tick(1); changeblock = C_WAIT; tick(1);
    changeblock = C_NP; tick(1); changeblock = C_WAIT;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b expected 0", busy); end
    tick(5);
    checks++; if ({piece_x, n_moved - b_moved} !== {4'd6, 32'd0}) begin
      errors++; $display("FAIL flush_no_move: got x=%0d pulses=%0d expected x=6 pulses=0", piece_x, n_moved - b_moved); end
  endtask

  task automatic test_reset_mid;
    b_moved = n_moved;
    changeblock = C_RIGHT; tick(1); changeblock = C_WAIT; tick(1);
    Resetn = 1'b0; tick(1); Resetn = 1'b1;
    checks++; if ({busy, piece_x, piece_y, piece_rot, piece_type} !== {1'b0, 4'd3, 5'd0, 2'd0, 3'd0}) begin
      errors++; $display("FAIL reset_mid: got %h expected %h", {busy, piece_x, piece_y, piece_rot, piece_type}, {1'b0, 4'd3, 5'd0, 2'd0, 3'd0}); end
    tick(6);
    checks++; if (n_moved - b_moved !== 0) begin errors++; $display("FAIL reset_mid_pulse: got %0d expected 0", n_moved - b_moved); end
  endtask

  task automatic test_spawn_blocked;
    board[0][4] = 1'b1;
    do_spawn(3'd2);
    checks++; if ({game_over, moved, piece_x, piece_type} !== {1'b1, 1'b0, 4'd3, 3'd2}) begin
      errors++; $display("FAIL spawn_blocked: got %h expected %h", {game_over, moved, piece_x, piece_type}, {1'b1, 1'b0, 4'd3, 3'd2}); end
    board[0][4] = 1'b0; tick(1);
  endtask

  task automatic test_rotate_wall;
    do_spawn(3'd0); do_cmd(C_ROT);
    repeat (4) do_cmd(C_RIGHT);
    checks++; if ({piece_x, piece_rot} !== {4'd7, 2'd1}) begin
      errors++; $display("FAIL rot_setup: got %h expected %h", {piece_x, piece_rot}, {4'd7, 2'd1}); end
    changeblock = C_ROT; tick(1); changeblock = C_WAIT;
`ifdef WALL_KICK_EN
    tick(9);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL kick_busy: got %b expected 1", busy); end
    tick(1);
    checks++; if ({moved, piece_x, piece_rot} !== {1'b1, 4'd6, 2'd2}) begin
      errors++; $display("FAIL kick_commit: got %h expected %h", {moved, piece_x, piece_rot}, {1'b1, 4'd6, 2'd2}); end
`else
    tick(5);
    checks++; if ({moved, lock, busy, piece_x, piece_rot} !== {3'b000, 4'd7, 2'd1}) begin
      errors++; $display("FAIL rot_blocked: got %h expected %h", {moved, lock, busy, piece_x, piece_rot}, {3'b000, 4'd7, 2'd1}); end
`endif
  endtask

  initial begin
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        board[r][c] = 1'b0;
    test_reset;
    test_spawn;
    test_left_oob;
    test_drop_lock;
    test_back_to_back;
    test_pending_drop;
    test_notplay;
    test_reset_mid;
    test_spawn_blocked;
    test_rotate_wall;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/piece_mover.md
Name: piece_mover

Overview:
Consumer of the gameplay FSM's 4-bit `changeblock` command code. It decodes each action code into a candidate move of the active tetromino and collision-checks the candidate's 4 cells against the board store through a 1-cycle-latency read port. It then commits or rejects the move. It owns the piece position, rotation and type registers that feed rendering and line-clear logic.

Parameters:
COLS, 10, board width in cells
ROWS, 20, board height in cells
SPAWN_X, 3, x of piece box origin on spawn
XW, 4, x coordinate width
YW, 5, y coordinate width

Ports:
Clk  in  1  clock
Resetn  in  1  synchronous active-low reset
changeblock  in  4  command code from gameplay FSM
spawn  in  1  pulse: place new piece
spawn_type  in  3  tetromino for spawn (0 I,1 O,2 T,3 S,4 Z,5 J,6 L,7 treated as I)
query_valid  out  1  board read strobe
query_x  out  XW  board read column
query_y  out  YW  board read row
query_occ  in  1  occupancy of cell queried previous cycle
piece_x  out  XW  box origin column
piece_y  out  YW  box origin row
piece_rot  out  2  rotation, clockwise quarter turns
piece_type  out  3  current tetromino
busy  out  1  check in progress
moved  out  1  1-cycle pulse: move/spawn committed
lock  out  1  1-cycle pulse: Drop/Down blocked
game_over  out  1  1-cycle pulse: spawn blocked

Behaviour:
- Reset: piece_x=SPAWN_X, piece_y=0, piece_rot=0, piece_type=0; busy, moved, lock, game_over, query_valid all 0; pending cleared; state IDLE.
- Codes:
  - 0010 Drop → y+1
  - 0011 Left → x-1
  - 0100 Right → x+1
  - 0101 Down → y+1
  - 0110 Rotate → rot+1 mod 4
  - 0001 and 0111-1010 (waits): no action. 1011-1111: ignored.
  - 0000 NotPlay: flush.
- Action codes execute once per cycle present; consecutive cycles of the same code are separate actions.
- Shapes: base cells in an S×S box (S=4 for I, 2 for O, 3 otherwise).
  - I (0,1)(1,1)(2,1)(3,1)
  - O (0,0)(1,0)(0,1)(1,1)
  - T (1,0)(0,1)(1,1)(2,1)
  - S (1,0)(2,0)(0,1)(1,1)
  - Z (0,0)(1,0)(1,1)(2,1)
  - J (0,0)(0,1)(1,1)(2,1)
  - L (2,0)(0,1)(1,1)(2,1)
  - Rotation r applies (dx,dy)→(S-1-dy,dx) r times. Cell index k follows list order.
- Arithmetic: candidate coordinates computed in XW+1/YW+1-bit two's complement. A cell with x<0, x≥COLS or y≥ROWS is out of bounds: query_valid=0 in its slot and it is treated as occupied.
- FSM IDLE→CHECK→RESOLVE→IDLE:
  - Cycle 0 (IDLE): accept the command and latch the candidate.
  - Cycles 1-4 (CHECK): issue cell k=0..3; busy=1.
  - Result for cell k is sampled in cycle k+2.
  - Cycle 5 (RESOLVE): last result is sampled, then registers update at the end of cycle 5. The moved, lock or game_over pulse is high in cycle 6, and IDLE resumes in cycle 6.
- Commit rules:
  - All 4 cells free → piece regs take the candidate, moved=1.
  - Drop/Down blocked → regs unchanged, lock=1.
  - Left/Right/Rotate blocked → regs unchanged, no pulse.
- Spawn:
  - Accepted only in IDLE; has priority over commands and pending.
  - Candidate is (SPAWN_X, 0, rot 0, spawn_type). piece_type loads immediately.
  - Free → moved=1. Blocked → game_over=1, piece regs still take the candidate.
  - spawn while busy is ignored.
- Pending (1 deep): an action code arriving while busy, or while IDLE is already serving pending, is latched into pending.
  - A new code overwrites pending, except a pending Drop is never overwritten by a non-Drop.
  - IDLE serves pending before the current code.
- NotPlay in any state: abort CHECK/RESOLVE without commit or pulse, clear pending, return to IDLE next cycle; piece regs retained.
- Reset mid-check: same as full reset; the outstanding query result is discarded.

Optional Feature:
WALL_KICK_EN:
- Defined: a blocked Rotate retries with candidate x-1, then x+1, each a further 5-cycle CHECK/RESOLVE pass. The first free candidate commits (moved=1). If all three fail, no change. busy stays high across retries.
- Undefined: a blocked Rotate simply fails after one pass.

Test Plan:
1. Reset, spawn type 2 (T) on an empty board → cycle 6 moved=1; piece (3,0,0,2); no lock or game_over.
2. T at x=0, changeblock=0011 for 1 cycle → cell (-1,1) out of bounds, query_valid low in that slot; no pulse; piece_x stays 0.
3. O at y=18, changeblock=0010 → lock pulse 6 cycles after the command; piece_y stays 18.
4. changeblock=0100 for 3 consecutive cycles on an empty board → 1st executes, 2nd pending, 3rd overwrites pending; final piece_x=SPAWN_X+2 after 12 cycles, two moved pulses.
5. changeblock=0000 asserted in CHECK cycle 2 of a Right → no moved pulse, piece_x unchanged, busy=0 the next cycle.
6. Spawn with query_occ=1 for cell 0 → game_over pulse in cycle 6, moved=0. With WALL_KICK_EN: I at x=7 rotating from rot 1 is blocked by the wall and commits at x=6 with a moved pulse.
